// File: rtl/uart_tx_block.sv
// uart_tx_block
// Serial transmitter that pairs with the UART receive block. A byte is
// written into a one-entry holding buffer. It is then sent on serial_out as
// one frame: a start bit (0), then 5, 7 or 8 data bits LSB first, then a
// stop bit (1). The data size and the bit period are sampled at the start of
// each frame and stay fixed until that frame ends.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   tx_data      byte to send (only the low data_size bits go out)
//   tx_load      one-cycle write strobe into the holding buffer
//   data_size    data bits per frame: 5, 7 or 8 (any other value means 8)
//   data_period  clocks per bit (0 and 1 mean 2)
//   serial_out   registered serial line, idles high
//   buffer_full  holding buffer occupied
//   tx_active    frame in progress
//   load_error   one-cycle pulse when a write was dropped (buffer full)
module uart_tx_block (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  tx_data,
  input  logic        tx_load,
  input  logic [3:0]  data_size,
  input  logic [13:0] data_period,
  output logic        serial_out,
  output logic        buffer_full,
  output logic        tx_active,
  output logic        load_error
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, next_state;
  logic [7:0]  buf_data;
  logic [7:0]  shift;
  logic [3:0]  bit_cnt;
  logic [3:0]  size_lat;
  logic [13:0] timer;
  logic [13:0] period_lat;
  logic [3:0]  size_eff;
  logic [13:0] period_eff;
  logic        serial_next;
  logic        expire;
  logic        last_bit;
  logic        take;

  assign size_eff   = (data_size == 4'd5 || data_size == 4'd7) ? data_size : 4'd8;
  assign period_eff = (data_period < 14'd2) ? 14'd2 : data_period;

  // The timer only counts while a frame is running, so expiry is gated by state.
  assign expire    = (state != IDLE) && (timer == period_lat - 14'd1);
  assign last_bit  = (bit_cnt == size_lat - 4'd1);
  // The buffer moves into the shifter when a frame can start: from IDLE, or at
  // the end of a stop bit so that back-to-back frames have no idle gap.
  assign take      = buffer_full && ((state == IDLE) || (state == STOP && expire));
  assign tx_active = (state != IDLE);

  always_comb begin
    next_state  = state;
    serial_next = serial_out;
    case (state)
      IDLE: begin
        serial_next = 1'b1;
        if (buffer_full) begin
          next_state  = START;
          serial_next = 1'b0;
        end
      end
      START: begin
        if (expire) begin
          next_state  = DATA;
          serial_next = shift[0];
        end
      end
      // shift[1] is the bit that will sit at position 0 after this edge's shift.
      DATA: begin
        if (expire) begin
          if (last_bit) begin
            next_state  = STOP;
            serial_next = 1'b1;
          end else begin
            serial_next = shift[1];
          end
        end
      end
      STOP: begin
        if (expire) begin
          if (buffer_full) begin
            next_state  = START;
            serial_next = 1'b0;
          end else begin
            next_state  = IDLE;
            serial_next = 1'b1;
          end
        end
      end
      default: begin
        next_state  = IDLE;
        serial_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      serial_out <= 1'b1;
    end else begin
      state      <= next_state;
      serial_out <= serial_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_data    <= 8'd0;
      buffer_full <= 1'b0;
      shift       <= 8'd0;
      bit_cnt     <= 4'd0;
      size_lat    <= 4'd0;
      timer       <= 14'd0;
      period_lat  <= 14'd0;
      load_error  <= 1'b0;
    end else begin
      load_error <= 1'b0;

      if (take) begin
        shift      <= buf_data;
        size_lat   <= size_eff;
        period_lat <= period_eff;
        timer      <= 14'd0;
        bit_cnt    <= 4'd0;
      end else if (state != IDLE) begin
        timer <= expire ? 14'd0 : timer + 14'd1;
        if (state == DATA && expire) begin
          shift   <= shift >> 1;
          bit_cnt <= bit_cnt + 4'd1;
        end
      end

      // A write in the same cycle as a transfer refills the buffer and is not an overrun.
      if (tx_load && (!buffer_full || take)) begin
        buf_data    <= tx_data;
        buffer_full <= 1'b1;
      end else if (take) begin
        buffer_full <= 1'b0;
      end else if (tx_load) begin
        load_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_block.sv
// tb_uart_tx_block
// Directed bench for uart_tx_block. The stimulus pushes one expected frame
// (byte, effective size, effective period) for each byte it expects on the
// line. A separate monitor detects each start bit. It pops the next expected
// frame and checks every clock of every bit, and it also rebuilds the byte.
// Other timing checks (latency, frame length, overrun pulse, reset) are made
// inline by the stimulus.
module tb_uart_tx_block;

  typedef struct {
    logic [7:0] data;
    int         size;
    int         period;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [7:0]  tx_data;
  logic        tx_load;
  logic [3:0]  data_size;
  logic [13:0] data_period;
  logic        serial_out;
  logic        buffer_full;
  logic        tx_active;
  logic        load_error;

  exp_t exp_q[$];
  int   assertions;
  int   failures;
  int   frames_done;
  bit   mon_busy;

  uart_tx_block dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_load     (tx_load),
    .data_size   (data_size),
    .data_period (data_period),
    .serial_out  (serial_out),
    .buffer_full (buffer_full),
    .tx_active   (tx_active),
    .load_error  (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    assertions++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Called on a negedge; strobes tx_load across exactly one rising edge.
  task automatic apply_stimulus(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] d, input int size, input int period);
    exp_t e;
    e.data   = d;
    e.size   = size;
    e.period = period;
    exp_q.push_back(e);
  endtask

  task automatic measure_active(input string name, input int expected);
    int n = 0;
    while (tx_active && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check_output(name, n, expected);
  endtask

  task automatic wait_idle(input string name);
    int  n = 0;
    bit  done = 1'b0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
      if (!tx_active && !buffer_full && exp_q.size() == 0 && !mon_busy) done = 1'b1;
    end
    check_output(name, int'(done), 1);
  endtask

  // Monitor: decodes frames off serial_out and compares them with the queue.
  initial begin
    exp_t       e;
    logic       prev_line;
    logic       want;
    logic [7:0] rx_byte;
    logic [7:0] mask;
    int         act;
    bit         aborted;
    bit         active_lost;
    prev_line = 1'b1;
    mon_busy  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && prev_line && !serial_out) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_frame", 1, 0);
        end else begin
          e           = exp_q.pop_front();
          mon_busy    = 1'b1;
          aborted     = 1'b0;
          active_lost = 1'b0;
          rx_byte     = 8'h00;
          for (int b = 0; b < e.size + 2 && !aborted; b++) begin
            if (b == 0)           want = 1'b0;
            else if (b <= e.size) want = e.data[b-1];
            else                  want = 1'b1;
            act = int'(want);
            for (int c = 0; c < e.period; c++) begin
              if (!(b == 0 && c == 0)) @(negedge clk);
              if (rst) begin
                aborted = 1'b1;
                break;
              end
              if (serial_out !== want) act = int'(serial_out);
              if (!tx_active) active_lost = 1'b1;
              if (c == 0 && b >= 1 && b <= e.size) rx_byte[b-1] = serial_out;
            end
            if (!aborted)
              check_output($sformatf("frame_%02h_bit%0d", e.data, b), act, int'(want));
          end
          if (!aborted) begin
            mask = 8'((16'd1 << e.size) - 16'd1);
            check_output($sformatf("rx_byte_%02h", e.data), int'(rx_byte), int'(e.data & mask));
            check_output($sformatf("active_in_frame_%02h", e.data), int'(active_lost), 0);
            frames_done++;
          end
          mon_busy = 1'b0;
        end
      end
      prev_line = serial_out;
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    assertions  = 0;
    failures    = 0;
    frames_done = 0;
    rst         = 1'b1;
    tx_data     = 8'h00;
    tx_load     = 1'b0;
    data_size   = 4'd8;
    data_period = 14'd10;

    // Reset values
    repeat (3) @(negedge clk);
    check_output("rst_serial_out", int'(serial_out), 1);
    check_output("rst_buffer_full", int'(buffer_full), 0);
    check_output("rst_tx_active", int'(tx_active), 0);
    check_output("rst_load_error", int'(load_error), 0);
    rst = 1'b0;
    @(negedge clk);

    // 8-bit frame at period 10, with load latency checks
    $display("[TB] 8-bit frame 0xA5, period 10");
    push_exp(8'hA5, 8, 10);
    apply_stimulus(8'hA5);
    check_output("lat_buffer_full_N", int'(buffer_full), 1);
    check_output("lat_tx_active_N", int'(tx_active), 0);
    check_output("lat_serial_out_N", int'(serial_out), 1);
    @(negedge clk);
    check_output("lat_serial_out_N1", int'(serial_out), 0);
    check_output("lat_tx_active_N1", int'(tx_active), 1);
    check_output("lat_buffer_full_N1", int'(buffer_full), 0);
    measure_active("frame8_p10_length", 100);
    check_output("idle_serial_out", int'(serial_out), 1);
    wait_idle("idle_after_a5");

    // 5-bit frame at period 4
    $display("[TB] 5-bit frame 0xFF, period 4");
    data_size   = 4'd5;
    data_period = 14'd4;
    push_exp(8'hFF, 5, 4);
    apply_stimulus(8'hFF);
    @(negedge clk);
    check_output("frame5_start_low", int'(serial_out), 0);
    measure_active("frame5_p4_length", 28);
    wait_idle("idle_after_ff");

    // Back-to-back frames
    $display("[TB] back-to-back 0x3C then 0xC3, period 5");
    data_size   = 4'd8;
    data_period = 14'd5;
    push_exp(8'h3C, 8, 5);
    push_exp(8'hC3, 8, 5);
    apply_stimulus(8'h3C);
    @(negedge clk);
    apply_stimulus(8'hC3);
    n = 0;
    while (buffer_full && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check_output("b2b_buffer_full_span", n, 49);
    check_output("b2b_second_start_active", int'(tx_active), 1);
    check_output("b2b_second_start_low", int'(serial_out), 0);
    measure_active("b2b_second_length", 50);
    wait_idle("idle_after_b2b");

    // Overrun: dropped write, original buffered byte is sent
    $display("[TB] overrun with 0x55");
    data_period = 14'd4;
    push_exp(8'h11, 8, 4);
    push_exp(8'h22, 8, 4);
    apply_stimulus(8'h11);
    @(negedge clk);
    check_output("ovr_load_error_idle", int'(load_error), 0);
    apply_stimulus(8'h22);
    apply_stimulus(8'h55);
    check_output("ovr_load_error_pulse", int'(load_error), 1);
    @(negedge clk);
    check_output("ovr_load_error_clear", int'(load_error), 0);
    check_output("ovr_buffer_kept", int'(buffer_full), 1);
    wait_idle("idle_after_overrun");

    // Reset during data bit 3 with a byte waiting in the buffer
    $display("[TB] reset mid-frame");
    data_period = 14'd8;
    push_exp(8'h52, 8, 8);
    apply_stimulus(8'h52);
    @(negedge clk);
    apply_stimulus(8'h99);
    repeat (33) @(negedge clk);
    check_output("rst_mid_bit3_low", int'(serial_out), 0);
    check_output("rst_mid_buffer_full_before", int'(buffer_full), 1);
    #1 rst = 1'b1;
    #1;
    check_output("rst_async_serial_out", int'(serial_out), 1);
    check_output("rst_async_buffer_full", int'(buffer_full), 0);
    check_output("rst_async_tx_active", int'(tx_active), 0);
    exp_q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_output("post_rst_idle_line", int'(serial_out), 1);
    push_exp(8'h81, 8, 8);
    apply_stimulus(8'h81);
    wait_idle("idle_after_81");

    // Mid-frame period change, then invalid size/period values
    $display("[TB] mid-frame period change and invalid settings");
    data_period = 14'd10;
    push_exp(8'h96, 8, 10);
    push_exp(8'h69, 8, 6);
    apply_stimulus(8'h96);
    @(negedge clk);
    apply_stimulus(8'h69);
    repeat (5) @(negedge clk);
    data_period = 14'd6;
    wait_idle("idle_after_cfg_change");

    data_size   = 4'd3;
    data_period = 14'd0;
    push_exp(8'hB4, 8, 2);
    apply_stimulus(8'hB4);
    @(negedge clk);
    measure_active("invalid_cfg_length", 20);
    wait_idle("idle_after_invalid");

    check_output("frames_completed", frames_done, 10);
    check_output("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
